// File: rtl/multicycle_decoder.sv
// Multi-cycle control sequencer for the ARM-subset processor.
// It latches the instruction fields on the fetch handshake and then walks
// FETCH/DECODE/EXEC/MEM/WB states. It drives the per-instruction strobes
// consumed by CondLogic, which applies the condition gating downstream.
// Every output is combinational from the state, the captured fields and
// MemReady. The outputs therefore hold steady while a memory access stalls.
`timescale 1ns/1ps

module multicycle_decoder (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] Instr,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        NextPC,
    output logic        AdrSrc,
    output logic        PCS,
    output logic        RegW,
    output logic        MemW,
    output logic        NoWrite,
    output logic [1:0]  FlagW,
    output logic [1:0]  ALUControl,
    output logic        ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        MemtoReg,
    output logic        Undef,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [5:0]  funct_q;
    logic [3:0]  rd_q;

    // Condition, Rn and the offset/operand field belong to the datapath.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{Instr[31:28], Instr[19:16], Instr[11:0]};

    // Decoded view of the captured fields
    logic [3:0]  cmd;
    logic        s_bit;
    logic        imm_bit;
    logic        up_bit;
    logic        load_bit;
    logic        rd_is_pc;

    assign cmd      = funct_q[4:1];
    assign s_bit    = funct_q[0];
    assign imm_bit  = funct_q[5];
    assign up_bit   = funct_q[3];
    assign load_bit = funct_q[0];
    assign rd_is_pc = (rd_q == 4'hF);

    logic        dp_valid;
    logic [1:0]  dp_alu;
    logic        dp_nowrite;
    logic        dp_arith;
    logic        instr_undef;

    assign State = state_q;

    // Capture Op/Funct/Rd only on the fetch handshake edge.
    // NOTE: the field register gets an explicit reset. Its contents feed
    // the output decode, so it must be deterministic straight out of reset.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            op_q    <= 2'b00;
            funct_q <= 6'b000000;
            rd_q    <= 4'b0000;
        end else if (IRWrite) begin
            op_q    <= Instr[27:26];
            funct_q <= Instr[25:20];
            rd_q    <= Instr[15:12];
        end
    end

    // Decode the data-processing command into ALU op, compare flag and flag class.
    // NOTE: every signal gets a default before the case statement. Any path
    // that skips an assignment would otherwise infer a latch.
    always_comb begin
        dp_valid   = 1'b1;
        dp_alu     = ALU_ADD;
        dp_nowrite = 1'b0;
        dp_arith   = 1'b1;
        case (cmd)
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: begin
                dp_alu   = ALU_AND;
                dp_arith = 1'b0;
            end
            4'b1100: begin
                dp_alu   = ALU_ORR;
                dp_arith = 1'b0;
            end
            4'b1010: begin
                dp_alu     = ALU_SUB;
                dp_nowrite = 1'b1;
            end
            4'b1011: begin
                dp_alu     = ALU_ADD;
                dp_nowrite = 1'b1;
            end
            default: dp_valid = 1'b0;
        endcase
    end

    assign instr_undef = (op_q == 2'b11) || ((op_q == 2'b00) && !dp_valid);

    // Next-state sequencing. Illegal codes fall back to FETCH.
    // NOTE: state updates use non-blocking assignment, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (MemReady) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (instr_undef) begin
                        state_q <= S_FETCH;
                    end else begin
                        case (op_q)
                            2'b00:   state_q <= imm_bit ? S_EXECI : S_EXECR;
                            2'b01:   state_q <= S_MEMADR;
                            2'b10:   state_q <= S_BRANCH;
                            default: state_q <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: state_q <= load_bit ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (MemReady) state_q <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (MemReady) state_q <= S_FETCH;
                end
                S_EXECR:  state_q <= S_ALUWB;
                S_EXECI:  state_q <= S_ALUWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_ALUWB:  state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Per-state strobes and datapath selects. Anything not named for a state stays 0.
    always_comb begin
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        NoWrite    = 1'b0;
        FlagW      = 2'b00;
        ALUControl = ALU_ADD;
        ALUSrc     = 1'b0;
        ImmSrc     = IMM_8;
        RegSrc     = 2'b00;
        MemtoReg   = 1'b0;
        Undef      = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = MemReady;
                NextPC  = MemReady;
            end
            S_DECODE: begin
                Undef = instr_undef;
            end
            S_MEMADR: begin
                ALUControl = up_bit ? ALU_ADD : ALU_SUB;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_12;
                RegSrc[1]  = !load_bit;
            end
            S_MEMRD: begin
                // Keep the address selects stable for the whole access
                ALUControl = up_bit ? ALU_ADD : ALU_SUB;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_12;
                AdrSrc     = 1'b1;
            end
            S_MEMWB: begin
                RegW     = 1'b1;
                MemtoReg = 1'b1;
                PCS      = rd_is_pc;
            end
            S_MEMWR: begin
                ALUControl = up_bit ? ALU_ADD : ALU_SUB;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_12;
                AdrSrc     = 1'b1;
                RegSrc[1]  = 1'b1;
                MemW       = MemReady;
            end
            S_EXECR: begin
                ALUControl = dp_alu;
                ALUSrc     = 1'b0;
            end
            S_EXECI: begin
                ALUControl = dp_alu;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_8;
            end
            S_ALUWB: begin
                // Operand selects are held so the ALU result stays valid for write-back
                ALUControl = dp_alu;
                ALUSrc     = imm_bit;
                RegW       = 1'b1;
                NoWrite    = dp_nowrite;
                PCS        = rd_is_pc && !dp_nowrite;
                if (s_bit) FlagW = dp_arith ? 2'b11 : 2'b10;
            end
            S_BRANCH: begin
                ALUControl = ALU_ADD;
                ALUSrc     = 1'b1;
                ImmSrc     = IMM_24;
                RegSrc[0]  = 1'b1;
                PCS        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
